// File: rtl/instr_encoder_loader.sv
// Program-load engine: packs decoded RV32I fields into instruction words and
// writes them to instruction memory. Optional IMM_RANGE_CHECK_EN flags immediates out of range.
module instr_encoder_loader #(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int                MAX_WORDS = 64,
  localparam int               CNT_W     = $clog2(MAX_WORDS) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_fmt,
  input  logic [6:0]        in_op,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [2:0]        in_funct3,
  input  logic              in_funct7b5,
  input  logic [31:0]       in_imm,
  input  logic              in_last,
  output logic              MemWrite,
  output logic [ADDR_W-1:0] WriteAddr,
  output logic [31:0]       WriteData,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  count,
  output logic              err,
  output logic [1:0]        o_dbg_state
);

  // Handshake: a field set transfers on a rising edge where in_valid && in_ready.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WORDS);
  localparam logic [31:0]      NOP     = 32'h0000_0013;

  state_t              r_state;
  state_t              w_next;
  logic [31:0]         r_word;
  logic                r_last;
  logic [CNT_W-1:0]    r_count;
  logic                r_err;
  logic [ADDR_W-1:0]   r_addr;

  logic [31:0]         w_enc;
  logic                w_enc_err;
  logic [6:0]          w_f7;
  logic                w_accept;
  logic [CNT_W-1:0]    w_count_inc;

  assign w_f7        = {1'b0, in_funct7b5, 5'b0};
  assign w_accept    = (r_state == S_LOAD) && in_valid;
  assign w_count_inc = r_count + CNT_W'(1);

  always_comb begin
    w_enc     = NOP;
    w_enc_err = 1'b0;
    case (in_fmt)
      3'd0: w_enc = {w_f7, in_rs2, in_rs1, in_funct3, in_rd, in_op};
      3'd1: begin
        // Immediate shifts carry funct7 in the upper immediate bits.
        if (in_op == 7'b0010011 && (in_funct3 == 3'b001 || in_funct3 == 3'b101))
          w_enc = {w_f7, in_imm[4:0], in_rs1, in_funct3, in_rd, in_op};
        else
          w_enc = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_op};
      end
      3'd2: w_enc = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_op};
      3'd3: begin
        w_enc     = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                     in_imm[4:1], in_imm[11], in_op};
        w_enc_err = in_imm[0];
      end
      3'd4: begin
        w_enc     = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_op};
        w_enc_err = in_imm[0];
      end
      3'd5: w_enc = {in_imm[31:12], in_rd, in_op};
      default: begin
        w_enc     = NOP;
        w_enc_err = 1'b1;
      end
    endcase
`ifdef IMM_RANGE_CHECK_EN
    case (in_fmt)
      3'd1, 3'd2: if (in_imm[31:11] != {21{in_imm[11]}}) w_enc_err = 1'b1;
      3'd3:       if (in_imm[31:12] != {20{in_imm[12]}}) w_enc_err = 1'b1;
      3'd4:       if (in_imm[31:20] != {12{in_imm[20]}}) w_enc_err = 1'b1;
      3'd5:       if (in_imm[11:0] != 12'd0)             w_enc_err = 1'b1;
      default:    ;
    endcase
`endif
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_LOAD;
      S_LOAD:  if (in_valid) w_next = S_WRITE;
      S_WRITE: w_next = (r_last || (w_count_inc == MAX_CNT)) ? S_DONE : S_LOAD;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_word  <= '0;
      r_last  <= 1'b0;
      r_count <= '0;
      r_err   <= 1'b0;
      r_addr  <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: if (start) begin
          r_count <= '0;
          r_err   <= 1'b0;
          r_addr  <= BASE_ADDR;
        end
        S_LOAD: if (w_accept) begin
          r_word <= w_enc;
          r_last <= in_last;
          r_err  <= r_err | w_enc_err;
        end
        S_WRITE: begin
          r_count <= w_count_inc;
          r_addr  <= r_addr + ADDR_W'(4);
        end
        default: ;
      endcase
    end
  end

  assign in_ready    = (r_state == S_LOAD);
  assign MemWrite    = (r_state == S_WRITE);
  assign busy        = (r_state != S_IDLE);
  assign done        = (r_state == S_DONE);
  assign WriteAddr   = r_addr;
  assign WriteData   = r_word;
  assign count       = r_count;
  assign err         = r_err;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Self-checking bench for instr_encoder_loader (MAX_WORDS=4): fixed RV32I vectors,
// random sessions against a reference encoder, overflow and mid-write reset.
module tb_instr_encoder_loader;

  localparam int MAXW  = 4;
  localparam int CNT_W = $clog2(MAXW) + 1;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        in_fmt;
  logic [6:0]        in_op;
  logic [4:0]        in_rd, in_rs1, in_rs2;
  logic [2:0]        in_funct3;
  logic              in_funct7b5;
  logic [31:0]       in_imm;
  logic              in_last;
  logic              MemWrite;
  logic [31:0]       WriteAddr;
  logic [31:0]       WriteData;
  logic              busy, done, err;
  logic [CNT_W-1:0]  count;
  logic [1:0]        dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  int n_writes = 0;
  logic [63:0] exp_q[$];
  logic [31:0] exp_addr;
  logic        exp_err;

  instr_encoder_loader #(.ADDR_W(32), .BASE_ADDR(32'h0), .MAX_WORDS(MAXW)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_fmt(in_fmt), .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_funct7b5(in_funct7b5), .in_imm(in_imm), .in_last(in_last),
    .MemWrite(MemWrite), .WriteAddr(WriteAddr), .WriteData(WriteData), .busy(busy),
    .done(done), .count(count), .err(err), .o_dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference encoder: {err, word}
  function automatic logic [32:0] ref_enc(input logic [2:0] fmt, input logic [6:0] op,
      input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
      input logic [2:0] f3, input logic f7, input logic [31:0] imm);
    logic [31:0] w;
    logic        e;
    w = '0;
    e = 1'b0;
    w[6:0] = op;
    case (fmt)
      3'd0: begin w[11:7] = rd; w[14:12] = f3; w[19:15] = rs1; w[24:20] = rs2; w[30] = f7; end
      3'd1: begin
        w[11:7] = rd; w[14:12] = f3; w[19:15] = rs1; w[31:20] = imm[11:0];
        if (op == 7'h13 && (f3 == 3'd1 || f3 == 3'd5)) begin w[31:25] = '0; w[30] = f7; end
      end
      3'd2: begin w[11:7] = imm[4:0]; w[14:12] = f3; w[19:15] = rs1; w[24:20] = rs2; w[31:25] = imm[11:5]; end
      3'd3: begin
        w[7] = imm[11]; w[11:8] = imm[4:1]; w[14:12] = f3; w[19:15] = rs1; w[24:20] = rs2;
        w[30:25] = imm[10:5]; w[31] = imm[12]; e = imm[0];
      end
      3'd4: begin
        w[11:7] = rd; w[19:12] = imm[19:12]; w[20] = imm[11]; w[30:21] = imm[10:1];
        w[31] = imm[20]; e = imm[0];
      end
      3'd5: begin w[11:7] = rd; w[31:12] = imm[31:12]; end
      default: begin w = 32'h0000_0013; e = 1'b1; end
    endcase
    return {e, w};
  endfunction

  // Scoreboard: every write strobe pops one expected {addr, data}.
  always @(negedge clk) begin
    if (MemWrite) begin
      logic [63:0] e;
      n_writes++;
      if (exp_q.size() == 0) begin
        check("unexpected_write", 64'(WriteAddr), 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check("write_addr", 64'(WriteAddr), 64'(e[63:32]));
        check("write_data", 64'(WriteData), 64'(e[31:0]));
      end
    end
  end

  task automatic start_session();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    exp_addr = 32'h0;
    exp_err  = 1'b0;
  endtask

  task automatic send(input logic [2:0] fmt, input logic [6:0] op, input logic [4:0] rd,
      input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3, input logic f7,
      input logic [31:0] imm, input logic last, input logic [31:0] exp_word, input logic exp_e);
    int n;
    in_fmt = fmt; in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_funct3 = f3; in_funct7b5 = f7; in_imm = imm; in_last = last;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      check("ready_timeout", 64'(in_ready), 64'd1);
    end else begin
      exp_q.push_back({exp_addr, exp_word});
      exp_addr = exp_addr + 32'd4;
      exp_err  = exp_err | exp_e;
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_rand(input logic last);
    logic [2:0]  fmt;
    logic [31:0] imm, r;
    logic [32:0] m;
    int v;
    fmt = 3'($urandom_range(0, 5));
    r = $urandom;
    case (fmt)
      3'd3:    begin v = int'($urandom_range(0, 4095)) * 2 - 4096; imm = 32'(v); end
      3'd4:    begin v = int'($urandom_range(0, 1048575)) * 2 - 1048576; imm = 32'(v); end
      3'd5:    imm = {r[19:0], 12'h000};
      default: begin v = int'($urandom_range(0, 4095)) - 2048; imm = 32'(v); end
    endcase
    in_op = 7'($urandom_range(0, 127));
    in_rd = 5'($urandom_range(0, 31)); in_rs1 = 5'($urandom_range(0, 31));
    in_rs2 = 5'($urandom_range(0, 31)); in_funct3 = 3'($urandom_range(0, 7));
    in_funct7b5 = 1'($urandom_range(0, 1));
    m = ref_enc(fmt, in_op, in_rd, in_rs1, in_rs2, in_funct3, in_funct7b5, imm);
    send(fmt, in_op, in_rd, in_rs1, in_rs2, in_funct3, in_funct7b5, imm, last, m[31:0], m[32]);
  endtask

  task automatic wait_done(input string tag, input int exp_cnt);
    int n;
    n = 0;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done"}, 64'(done), 64'd1);
    check({tag, "_count"}, 64'(count), 64'(exp_cnt));
    check({tag, "_err"}, 64'(err), 64'(exp_err));
    @(negedge clk);
    check({tag, "_idle"}, 64'(busy), 64'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_memwrite"}, 64'(MemWrite), 64'd0);
    check({tag, "_ready"}, 64'(in_ready), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_count"}, 64'(count), 64'd0);
    check({tag, "_err"}, 64'(err), 64'd0);
    check({tag, "_addr"}, 64'(WriteAddr), 64'd0);
    check({tag, "_data"}, 64'(WriteData), 64'd0);
  endtask

  initial begin
    int wr_before, nw;
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_fmt = '0; in_op = '0; in_rd = '0;
    in_rs1 = '0; in_rs2 = '0; in_funct3 = '0; in_funct7b5 = 1'b0; in_imm = '0; in_last = 1'b0;
    exp_addr = '0; exp_err = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    check("reset_state", 64'(dbg_state), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // R-type add, then sub and srai in one session
    start_session();
    send(3'd0, 7'b0110011, 5'd3, 5'd1, 5'd2, 3'd0, 1'b0, 32'd0, 1'b1, 32'h002081B3, 1'b0);
    wait_done("r_add", 1);
    start_session();
    send(3'd0, 7'b0110011, 5'd3, 5'd1, 5'd2, 3'd0, 1'b1, 32'd0, 1'b0, 32'h402081B3, 1'b0);
    send(3'd1, 7'b0010011, 5'd1, 5'd2, 5'd0, 3'd5, 1'b1, 32'd3, 1'b1, 32'h40315093, 1'b0);
    wait_done("r_sub", 2);

    // lw/sw back to back; a start during LOAD must be ignored
    start_session();
    send(3'd1, 7'b0000011, 5'd6, 5'd9, 5'd0, 3'd2, 1'b0, 32'hFFFF_FFFC, 1'b0, 32'hFFC4A303, 1'b0);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_ignored_count", 64'(count), 64'd1);
    send(3'd2, 7'b0100011, 5'd0, 5'd9, 5'd6, 3'd2, 1'b0, 32'd8, 1'b1, 32'h0064A423, 1'b0);
    wait_done("ls", 2);

    // Branch, aligned and odd offset
    start_session();
    send(3'd3, 7'b1100011, 5'd0, 5'd4, 5'd4, 3'd0, 1'b0, 32'd8, 1'b0, 32'h00420463, 1'b0);
    send(3'd3, 7'b1100011, 5'd0, 5'd4, 5'd4, 3'd0, 1'b0, 32'd9, 1'b1, 32'h00420463, 1'b1);
    wait_done("branch", 2);

    // Invalid format: NOP with sticky err, cleared by the next start
    start_session();
    send(3'd6, 7'b0110011, 5'd1, 5'd1, 5'd1, 3'd0, 1'b0, 32'd0, 1'b1, 32'h00000013, 1'b1);
    wait_done("badfmt", 1);
    repeat (3) @(negedge clk);
    check("err_sticky", 64'(err), 64'd1);
    start_session();
    check("err_cleared", 64'(err), 64'd0);
    send(3'd5, 7'b0110111, 5'd5, 5'd0, 5'd0, 3'd0, 1'b0, 32'h12345000, 1'b0, 32'h123452B7, 1'b0);
    send(3'd4, 7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd8, 1'b1, 32'h008000EF, 1'b0);
    wait_done("uj", 2);

    // Overflow: no last, capacity ends the session
    start_session();
    for (int i = 0; i < MAXW; i++) send_rand(1'b0);
    wait_done("overflow", MAXW);
    wr_before = n_writes;
    in_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      repeat (3) @(negedge clk);
      check("overflow_ready_low", 64'(in_ready), 64'd0);
    end
    in_valid = 1'b0;
    check("overflow_no_write", 64'(n_writes - wr_before), 64'd0);

    // Random sessions
    for (int s = 0; s < 4; s++) begin
      nw = $urandom_range(1, MAXW);
      start_session();
      for (int i = 0; i < nw; i++) send_rand(i == nw - 1);
      wait_done("rand", nw);
    end

    // Reset during WRITE aborts the session
    start_session();
    send(3'd0, 7'b0110011, 5'd3, 5'd1, 5'd2, 3'd0, 1'b0, 32'd0, 1'b0, 32'h002081B3, 1'b0);
    check("mid_in_write", 64'(MemWrite), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    check_all_zero("mid_reset");
    reset = 1'b0;
    wr_before = n_writes;
    in_valid = 1'b1;
    repeat (4) @(negedge clk);
    in_valid = 1'b0;
    check("mid_reset_no_write", 64'(n_writes - wr_before), 64'd0);

    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
